// File: rtl/wash_pkg.sv
// Shared definitions for the washing-machine sequencer: state codes (also used by
// the display path), phase bit positions, mode masks and mask-duration helpers.
package wash_pkg;

  typedef enum logic [2:0] {
    sShutDown = 3'd0,
    sBegin    = 3'd1,
    sSet      = 3'd2,
    sRun      = 3'd3,
    sError    = 3'd4,
    sPause    = 3'd5,
    sFinish   = 3'd6
  } washState_t;

  localparam int PH_WIN   = 7;
  localparam int PH_WASH  = 6;
  localparam int PH_ROUT  = 5;
  localparam int PH_RSPIN = 4;
  localparam int PH_RIN   = 3;
  localparam int PH_RINSE = 2;
  localparam int PH_DOUT  = 1;
  localparam int PH_DSPIN = 0;

  localparam logic [7:0] MASK_MODE1 = 8'hFF;
  localparam logic [7:0] MASK_MODE2 = 8'hC0;
  localparam logic [7:0] MASK_MODE3 = 8'h3F;
  localparam logic [7:0] MASK_MODE4 = 8'h03;

  // Phase durations indexed by phase bit, so dur[PH_WIN] is the wash water-in time.
  typedef logic [7:0][5:0] durArr_t;
  localparam durArr_t DEFAULT_DUR = {6'd3, 6'd9, 6'd3, 6'd3, 6'd3, 6'd6, 6'd3, 6'd6};

  function automatic logic [7:0] modeMask(input logic [2:0] mode);
    logic [7:0] m;
    case (mode)
      3'd2:    m = MASK_MODE2;
      3'd3:    m = MASK_MODE3;
      3'd4:    m = MASK_MODE4;
      default: m = MASK_MODE1;
    endcase
    return m;
  endfunction

  function automatic logic [5:0] mask_total(input logic [7:0] mask,
                                            input durArr_t dur = DEFAULT_DUR);
    logic [5:0] sum;
    sum = '0;
    for (int i = 0; i < 8; i++)
      if (mask[i]) sum = sum + dur[i];
    return sum;
  endfunction

  // Highest enabled phase strictly below `below`; result is {found, index}.
  function automatic logic [3:0] nextPhase(input logic [7:0] mask, input logic [3:0] below);
    logic [3:0] r;
    r = '0;
    for (int i = 0; i < 8; i++)
      if (mask[i] && (4'(i) < below)) r = {1'b1, 3'(i)};
    return r;
  endfunction

endpackage

// File: rtl/wash_phase_timer.sv
// Loadable 6-bit down-counter for the current wash phase; `last` flags the final tick.
module wash_phase_timer
(
  input  logic       cp,
  input  logic       rst_n,
  input  logic       clear,
  input  logic       load,
  input  logic       hold,
  input  logic       tick,
  input  logic [5:0] loadVal,
  output logic [5:0] count,
  output logic       last
);

  always_ff @(posedge cp or negedge rst_n) begin
    if (!rst_n)                          count <= '0;
    else if (clear)                      count <= '0;
    else if (load)                       count <= loadVal;
    else if (!hold && tick && count != '0) count <= count - 6'd1;
  end

  assign last = (count == 6'd1);

endmodule

// File: rtl/wash_controller.sv
// Washing-machine program sequencer: key/tick/lid inputs to registered state, LED
// data and three digit values for the display path.
module wash_controller
  import wash_pkg::*;
#(
  parameter int T_WIN    = 3,
  parameter int T_WASH   = 9,
  parameter int T_ROUT   = 3,
  parameter int T_RSPIN  = 3,
  parameter int T_RIN    = 3,
  parameter int T_RINSE  = 6,
  parameter int T_DOUT   = 3,
  parameter int T_DSPIN  = 6,
  parameter int T_BEGIN  = 2,
  parameter int T_FINISH = 3
)
(
  input  logic       cp,
  input  logic       rst_n,
  input  logic       tick,
  input  logic       powerKey,
  input  logic       startKey,
  input  logic       modeKey,
  input  logic       lidOpen,
  output logic [2:0] state,
  output logic [9:0] data,
  output logic [5:0] outLeft,
  output logic [5:0] outMiddle,
  output logic [5:0] outRight
);

  localparam durArr_t DUR = {6'(T_WIN), 6'(T_WASH), 6'(T_ROUT), 6'(T_RSPIN),
                             6'(T_RIN), 6'(T_RINSE), 6'(T_DOUT), 6'(T_DSPIN)};

  washState_t st, nxtSt;
  logic [2:0] phase, nxtPhase;
  logic [2:0] mode, nxtMode;
  logic [5:0] total, nxtTotal;
  logic [5:0] tickCnt, nxtTickCnt;
  logic [7:0] curMask;
  logic [3:0] firstInf, nextInf;
  logic       tmrClear, tmrLoad, tmrHold, phaseLast;
  logic [5:0] tmrLoadVal, phaseCount;

  function automatic logic [9:0] dataFor(input washState_t s, input logic [2:0] ph,
                                         input logic [7:0] mask);
    logic [9:0] d;
    d = '0;
    d[8] = (s != sShutDown);
    case (s)
      sSet:                 begin d[9] = 1'b1; d[7:0] = mask; end
      sRun, sPause, sError: d[7:0] = 8'd1 << ph;
      default:              ;
    endcase
    return d;
  endfunction

  assign curMask  = modeMask(mode);
  assign firstInf = nextPhase(curMask, 4'd8);
  assign nextInf  = nextPhase(curMask, {1'b0, phase});

  // The phase counter only moves on a tick that leaves the machine in run.
  assign tmrHold = !(st == sRun && !powerKey && !lidOpen && !startKey);

  always_comb begin
    nxtSt      = st;
    nxtPhase   = phase;
    nxtMode    = mode;
    nxtTotal   = total;
    nxtTickCnt = tickCnt;
    tmrClear   = 1'b0;
    tmrLoad    = 1'b0;
    tmrLoadVal = '0;
    if (st == sShutDown) begin
      if (powerKey) begin
        nxtSt      = sBegin;
        nxtTickCnt = '0;
      end
    end else if (powerKey) begin
      nxtSt    = sShutDown;
      nxtTotal = '0;
      nxtPhase = '0;
      tmrClear = 1'b1;
    end else begin
      case (st)
        sBegin: if (tick) begin
          if (tickCnt + 6'd1 == 6'(T_BEGIN)) begin
            nxtSt    = sSet;
            nxtTotal = mask_total(curMask, DUR);
          end else nxtTickCnt = tickCnt + 6'd1;
        end
        sSet: begin
          if (startKey && firstInf[3]) begin
            nxtSt      = sRun;
            nxtPhase   = firstInf[2:0];
            nxtTotal   = mask_total(curMask, DUR);
            tmrLoad    = 1'b1;
            tmrLoadVal = DUR[firstInf[2:0]];
          end else if (modeKey) begin
            nxtMode  = (mode == 3'd4) ? 3'd1 : mode + 3'd1;
            nxtTotal = mask_total(modeMask(nxtMode), DUR);
          end
        end
        sRun: begin
          if (lidOpen)       nxtSt = sError;
          else if (startKey) nxtSt = sPause;
          else if (tick) begin
            nxtTotal = total - 6'd1;
            if (phaseLast && nextInf[3]) begin
              nxtPhase   = nextInf[2:0];
              tmrLoad    = 1'b1;
              tmrLoadVal = DUR[nextInf[2:0]];
            end else if (phaseLast) begin
              nxtSt      = sFinish;
              nxtTickCnt = '0;
            end
          end
        end
        sPause: if (startKey) nxtSt = sRun;
        sError: if (!lidOpen) nxtSt = sRun;
        sFinish: if (tick) begin
          if (tickCnt + 6'd1 == 6'(T_FINISH)) begin
            nxtSt    = sShutDown;
            nxtTotal = '0;
            tmrClear = 1'b1;
          end else nxtTickCnt = tickCnt + 6'd1;
        end
        default: nxtSt = sShutDown;
      endcase
    end
  end

  always_ff @(posedge cp or negedge rst_n) begin
    if (!rst_n) begin
      st        <= sShutDown;
      phase     <= '0;
      mode      <= 3'd1;
      total     <= '0;
      tickCnt   <= '0;
      data      <= '0;
      outMiddle <= '0;
    end else begin
      st      <= nxtSt;
      phase   <= nxtPhase;
      mode    <= nxtMode;
      total   <= nxtTotal;
      tickCnt <= nxtTickCnt;
      data    <= dataFor(nxtSt, nxtPhase, modeMask(nxtMode));
      case (nxtSt)
        sShutDown:                  outMiddle <= '0;
        sSet, sRun, sPause, sError: outMiddle <= {3'b000, nxtMode};
        default:                    ;
      endcase
    end
  end

  wash_phase_timer uPhaseTimer (
    .cp      (cp),
    .rst_n   (rst_n),
    .clear   (tmrClear),
    .load    (tmrLoad),
    .hold    (tmrHold),
    .tick    (tick),
    .loadVal (tmrLoadVal),
    .count   (phaseCount),
    .last    (phaseLast)
  );

  assign state    = st;
  assign outLeft  = total;
  assign outRight = phaseCount;

endmodule
